// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter
//   Arbitrates two writeback sources (ALU and load unit) onto a single
//   register-file write port. It also keeps a scoreboard of registers that
//   have outstanding writes and counts cycles in which both sources compete.
//
// Ports
//   clk, reset                 clock; synchronous active-low reset
//   alu_valid/rd/data, alu_ready   ALU writeback request and grant
//   mem_valid/rd/data, mem_ready   load writeback request and grant
//   alloc_valid, alloc_rd      issue-stage allocation of an outstanding write
//   rs1_query/rs2_query        hazard queries -> rs1_busy/rs2_busy
//   wr_en, wr_addr, wr_data    registered register-file write port
//   pending                    scoreboard bitmap (bit 0 always 0)
//   conflict_cnt               saturating count of dual-request cycles
module regfile_wb_arbiter #(
  parameter int unsigned CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             alu_valid,
  input  logic [4:0]       alu_rd,
  input  logic [31:0]      alu_data,
  output logic             alu_ready,
  input  logic             mem_valid,
  input  logic [4:0]       mem_rd,
  input  logic [31:0]      mem_data,
  output logic             mem_ready,
  input  logic             alloc_valid,
  input  logic [4:0]       alloc_rd,
  input  logic [4:0]       rs1_query,
  input  logic [4:0]       rs2_query,
  output logic             rs1_busy,
  output logic             rs2_busy,
  output logic             wr_en,
  output logic [4:0]       wr_addr,
  output logic [31:0]      wr_data,
  output logic [31:0]      pending,
  output logic [CNT_W-1:0] conflict_cnt
);

  typedef enum logic {
    GNT_ALU = 1'b0,
    GNT_MEM = 1'b1
  } grant_e;

  grant_e           last_grant_q, last_grant_d;
  logic             wr_en_q, wr_en_d;
  logic [4:0]       wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic [31:0]      pending_q, pending_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic             hs;
  logic [4:0]       hs_rd;
  logic [31:0]      hs_data;

  // Grant: a lone requester always wins; on a conflict the side that was
  // not granted last wins. Nothing is granted while reset is held low.
  always_comb begin
    alu_ready = 1'b0;
    mem_ready = 1'b0;
    if (reset) begin
      if (alu_valid && (!mem_valid || last_grant_q == GNT_MEM)) begin
        alu_ready = 1'b1;
      end else if (mem_valid) begin
        mem_ready = 1'b1;
      end
    end
  end

  assign hs      = alu_ready | mem_ready;
  assign hs_rd   = alu_ready ? alu_rd : mem_rd;
  assign hs_data = alu_ready ? alu_data : mem_data;

  always_comb begin
    last_grant_d = last_grant_q;
    if (alu_ready) begin
      last_grant_d = GNT_ALU;
    end else if (mem_ready) begin
      last_grant_d = GNT_MEM;
    end

    // Writes to x0 are accepted but never reach the register file;
    // address/data only move when a real write is issued.
    wr_en_d   = hs && (hs_rd != 5'd0);
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (wr_en_d) begin
      wr_addr_d = hs_rd;
      wr_data_d = hs_data;
    end

    // Clear before set so a same-edge allocation of the retiring register
    // survives: the new writer owns the bit.
    pending_d = pending_q;
    if (hs) begin
      pending_d[hs_rd] = 1'b0;
    end
    if (alloc_valid) begin
      pending_d[alloc_rd] = 1'b1;
    end
    pending_d[0] = 1'b0;

    cnt_d = cnt_q;
    if (alu_valid && mem_valid && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      last_grant_q <= GNT_MEM;
      wr_en_q      <= 1'b0;
      wr_addr_q    <= '0;
      wr_data_q    <= '0;
      pending_q    <= '0;
      cnt_q        <= '0;
    end else begin
      last_grant_q <= last_grant_d;
      wr_en_q      <= wr_en_d;
      wr_addr_q    <= wr_addr_d;
      wr_data_q    <= wr_data_d;
      pending_q    <= pending_d;
      cnt_q        <= cnt_d;
    end
  end

  // Bit 0 of the scoreboard is forced low, so a query of x0 is never busy.
  assign rs1_busy     = pending_q[rs1_query];
  assign rs2_busy     = pending_q[rs2_query];
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign pending      = pending_q;
  assign conflict_cnt = cnt_q;

endmodule

// File: tb/tb_regfile_wb_arbiter.sv
module tb_regfile_wb_arbiter;

  localparam int unsigned CNT_W = 4;

  logic             clk;
  logic             reset;
  logic             alu_valid;
  logic [4:0]       alu_rd;
  logic [31:0]      alu_data;
  logic             alu_ready;
  logic             mem_valid;
  logic [4:0]       mem_rd;
  logic [31:0]      mem_data;
  logic             mem_ready;
  logic             alloc_valid;
  logic [4:0]       alloc_rd;
  logic [4:0]       rs1_query;
  logic [4:0]       rs2_query;
  logic             rs1_busy;
  logic             rs2_busy;
  logic             wr_en;
  logic [4:0]       wr_addr;
  logic [31:0]      wr_data;
  logic [31:0]      pending;
  logic [CNT_W-1:0] conflict_cnt;

  int total;
  int bad;

  regfile_wb_arbiter #(.CNT_W(CNT_W)) dut (
    .clk          (clk),
    .reset        (reset),
    .alu_valid    (alu_valid),
    .alu_rd       (alu_rd),
    .alu_data     (alu_data),
    .alu_ready    (alu_ready),
    .mem_valid    (mem_valid),
    .mem_rd       (mem_rd),
    .mem_data     (mem_data),
    .mem_ready    (mem_ready),
    .alloc_valid  (alloc_valid),
    .alloc_rd     (alloc_rd),
    .rs1_query    (rs1_query),
    .rs2_query    (rs2_query),
    .rs1_busy     (rs1_busy),
    .rs2_busy     (rs2_busy),
    .wr_en        (wr_en),
    .wr_addr      (wr_addr),
    .wr_data      (wr_data),
    .pending      (pending),
    .conflict_cnt (conflict_cnt)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Advance past the next active edge; outputs are sampled 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    alu_valid   = 1'b0;
    alu_rd      = 5'd0;
    alu_data    = 32'd0;
    mem_valid   = 1'b0;
    mem_rd      = 5'd0;
    mem_data    = 32'd0;
    alloc_valid = 1'b0;
    alloc_rd    = 5'd0;
  endtask

  task automatic do_reset();
    idle_inputs();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    idle_inputs();
    reset    = 1'b0;
    alu_valid = 1'b1;
    alu_rd    = 5'd6;
    mem_valid = 1'b1;
    mem_rd    = 5'd8;
    #1;
    total++;
    if ({alu_ready, mem_ready} !== 2'b00) begin
      bad++; $display("FAIL reset_ready got=%b exp=00", {alu_ready, mem_ready});
    end
    tick();
    total++;
    if (pending !== 32'd0) begin
      bad++; $display("FAIL reset_pending got=%h exp=0", pending);
    end
    total++;
    if ({wr_en, wr_addr, wr_data} !== 38'd0) begin
      bad++; $display("FAIL reset_wr got=%b/%0d/%h exp=0/0/0", wr_en, wr_addr, wr_data);
    end
    total++;
    if (conflict_cnt !== 4'd0) begin
      bad++; $display("FAIL reset_cnt got=%0d exp=0", conflict_cnt);
    end
    idle_inputs();
    reset = 1'b1;
  endtask

  task automatic test_single();
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'h1234;
    #1;
    total++;
    if ({alu_ready, mem_ready} !== 2'b10) begin
      bad++; $display("FAIL single_ready got=%b exp=10", {alu_ready, mem_ready});
    end
    tick();
    alu_valid = 1'b0;
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd5, 32'h1234}) begin
      bad++; $display("FAIL single_wr got=%b/%0d/%h exp=1/5/1234", wr_en, wr_addr, wr_data);
    end
    // mem alone after ALU was granted last
    mem_valid = 1'b1;
    mem_rd    = 5'd11;
    mem_data  = 32'hCAFE_0011;
    #1;
    total++;
    if ({alu_ready, mem_ready} !== 2'b01) begin
      bad++; $display("FAIL single_mem_ready got=%b exp=01", {alu_ready, mem_ready});
    end
    tick();
    mem_valid = 1'b0;
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b1, 5'd11, 32'hCAFE_0011}) begin
      bad++; $display("FAIL single_mem_wr got=%b/%0d/%h exp=1/11/cafe0011", wr_en, wr_addr, wr_data);
    end
  endtask

  task automatic test_conflict();
    logic [1:0] exp_rdy [4] = '{2'b10, 2'b01, 2'b10, 2'b01};
    logic [4:0] exp_ad  [4] = '{5'd3, 5'd7, 5'd3, 5'd7};
    do_reset();
    alu_valid = 1'b1;
    alu_rd    = 5'd3;
    alu_data  = 32'hAAAA_0003;
    mem_valid = 1'b1;
    mem_rd    = 5'd7;
    mem_data  = 32'hBBBB_0007;
    for (int i = 0; i < 4; i++) begin
      #1;
      total++;
      if ({alu_ready, mem_ready} !== exp_rdy[i]) begin
        bad++; $display("FAIL conflict_grant%0d got=%b exp=%b", i, {alu_ready, mem_ready}, exp_rdy[i]);
      end
      tick();
      total++;
      if ({wr_en, wr_addr} !== {1'b1, exp_ad[i]}) begin
        bad++; $display("FAIL conflict_wr%0d got=%b/%0d exp=1/%0d", i, wr_en, wr_addr, exp_ad[i]);
      end
    end
    idle_inputs();
    #1;
    total++;
    if ({alu_ready, mem_ready} !== 2'b00) begin
      bad++; $display("FAIL idle_ready got=%b exp=00", {alu_ready, mem_ready});
    end
    total++;
    if (conflict_cnt !== 4'd4) begin
      bad++; $display("FAIL conflict_cnt got=%0d exp=4", conflict_cnt);
    end
    tick();
    total++;
    if ({wr_en, wr_addr, wr_data} !== {1'b0, 5'd7, 32'hBBBB_0007}) begin
      bad++; $display("FAIL idle_hold got=%b/%0d/%h exp=0/7/bbbb0007", wr_en, wr_addr, wr_data);
    end
    total++;
    if (conflict_cnt !== 4'd4) begin
      bad++; $display("FAIL idle_cnt got=%0d exp=4", conflict_cnt);
    end
    // last grant was MEM, next conflict must go to ALU
    alu_valid = 1'b1;
    mem_valid = 1'b1;
    #1;
    total++;
    if ({alu_ready, mem_ready} !== 2'b10) begin
      bad++; $display("FAIL rr_after_idle got=%b exp=10", {alu_ready, mem_ready});
    end
    idle_inputs();
  endtask

  task automatic test_scoreboard();
    do_reset();
    alloc_valid = 1'b1;
    alloc_rd    = 5'd9;
    rs1_query   = 5'd9;
    tick();
    alloc_valid = 1'b0;
    total++;
    if (pending !== 32'h0000_0200) begin
      bad++; $display("FAIL sb_set got=%h exp=00000200", pending);
    end
    mem_valid = 1'b1;
    mem_rd    = 5'd9;
    mem_data  = 32'h0000_0999;
    #1;
    total++;
    if ({mem_ready, rs1_busy} !== 2'b11) begin
      bad++; $display("FAIL sb_busy_before got=%b exp=11", {mem_ready, rs1_busy});
    end
    tick();
    mem_valid = 1'b0;
    total++;
    if ({pending[9], rs1_busy} !== 2'b00) begin
      bad++; $display("FAIL sb_clear got=%b exp=00", {pending[9], rs1_busy});
    end
    // double allocation does not count: one retirement clears it
    alloc_valid = 1'b1;
    alloc_rd    = 5'd12;
    tick();
    tick();
    alloc_valid = 1'b0;
    alu_valid   = 1'b1;
    alu_rd      = 5'd12;
    tick();
    alu_valid = 1'b0;
    total++;
    if (pending !== 32'd0) begin
      bad++; $display("FAIL sb_no_count got=%h exp=0", pending);
    end
  endtask

  task automatic test_same_edge();
    alloc_valid = 1'b1;
    alloc_rd    = 5'd4;
    alu_valid   = 1'b1;
    alu_rd      = 5'd4;
    alu_data    = 32'h4444_4444;
    tick();
    idle_inputs();
    total++;
    if (pending !== 32'h0000_0010) begin
      bad++; $display("FAIL same_edge_pending got=%h exp=00000010", pending);
    end
    total++;
    if ({wr_en, wr_addr} !== {1'b1, 5'd4}) begin
      bad++; $display("FAIL same_edge_wr got=%b/%0d exp=1/4", wr_en, wr_addr);
    end
  endtask

  task automatic test_zero();
    do_reset();
    alloc_valid = 1'b1;
    alloc_rd    = 5'd0;
    alu_valid   = 1'b1;
    alu_rd      = 5'd0;
    alu_data    = 32'hDEAD_0000;
    rs2_query   = 5'd0;
    #1;
    total++;
    if (alu_ready !== 1'b1) begin
      bad++; $display("FAIL zero_ready got=%b exp=1", alu_ready);
    end
    tick();
    idle_inputs();
    total++;
    if ({pending, wr_en, rs2_busy} !== {32'd0, 1'b0, 1'b0}) begin
      bad++; $display("FAIL zero_effect got=%h/%b/%b exp=0/0/0", pending, wr_en, rs2_busy);
    end
    total++;
    if (wr_data !== 32'd0) begin
      bad++; $display("FAIL zero_data got=%h exp=0", wr_data);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    alloc_valid = 1'b1;
    alloc_rd    = 5'd5;
    tick();
    alloc_rd = 5'd9;
    tick();
    alloc_valid = 1'b0;
    total++;
    if (pending !== 32'h0000_0220) begin
      bad++; $display("FAIL mid_setup got=%h exp=00000220", pending);
    end
    alu_valid = 1'b1;
    alu_rd    = 5'd5;
    alu_data  = 32'h5555_5555;
    reset     = 1'b0;
    #1;
    total++;
    if ({alu_ready, mem_ready} !== 2'b00) begin
      bad++; $display("FAIL mid_ready got=%b exp=00", {alu_ready, mem_ready});
    end
    tick();
    total++;
    if ({pending, wr_en} !== {32'd0, 1'b0}) begin
      bad++; $display("FAIL mid_clear got=%h/%b exp=0/0", pending, wr_en);
    end
    reset     = 1'b1;
    mem_valid = 1'b1;
    mem_rd    = 5'd2;
    #1;
    total++;
    if ({alu_ready, mem_ready} !== 2'b10) begin
      bad++; $display("FAIL mid_first_grant got=%b exp=10", {alu_ready, mem_ready});
    end
    tick();
    idle_inputs();
  endtask

  task automatic test_saturate();
    do_reset();
    alu_valid = 1'b1;
    alu_rd    = 5'd1;
    mem_valid = 1'b1;
    mem_rd    = 5'd2;
    for (int i = 0; i < 14; i++) tick();
    total++;
    if (conflict_cnt !== 4'd14) begin
      bad++; $display("FAIL sat_below got=%0d exp=14", conflict_cnt);
    end
    for (int i = 0; i < 6; i++) tick();
    total++;
    if (conflict_cnt !== 4'd15) begin
      bad++; $display("FAIL sat_hold got=%0d exp=15", conflict_cnt);
    end
    idle_inputs();
  endtask

  initial begin
    total     = 0;
    bad       = 0;
    reset     = 1'b1;
    rs1_query = 5'd0;
    rs2_query = 5'd0;
    idle_inputs();
    #2;
    test_reset();
    test_single();
    test_conflict();
    test_scoreboard();
    test_same_edge();
    test_zero();
    test_reset_mid();
    test_saturate();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
